// File: rtl/spi_arb_pkg.sv
// Shared types and encodings for the SPI bus arbiter.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT0     = 2'b01;
    localparam logic [1:0] GRANT1     = 2'b10;

    // req1 takes the bus when it is alone, or when req0 has starved it long enough.
    function automatic logic pick_req1(input logic r0, input logic r1, input logic starved);
        return r1 && (starved || !r0);
    endfunction

endpackage

// File: rtl/spi_bus_arb.sv
// Two-requester arbiter in front of a single SPI master: serialises 16-bit
// frames, inserts an inter-frame gap, bounds req1 starvation and aborts
// frames whose spi_done never arrives.
module spi_bus_arb #(
    parameter int unsigned GAP_CYC     = 4,
    parameter int unsigned STARVE_LIM  = 3,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] cmd0,
    input  logic [15:0] cmd1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] rd0,
    output logic [15:0] rd1,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_rd,
    output logic [1:0]  grant,
    output logic        busy,
    input  logic        clr_err,
    output logic        timeout_err
);

    import spi_arb_pkg::*;

    localparam int unsigned GW = $clog2(GAP_CYC + 1);
    localparam int unsigned SW = $clog2(STARVE_LIM + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYC - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
    localparam logic [TW-1:0] XFER_LAST  = TW'(TIMEOUT_CYC - 1);

    arb_state_t    state, state_nx;
    logic [GW-1:0] gap_cnt, gap_nx;
    logic [SW-1:0] starve_cnt, starve_nx;
    logic [TW-1:0] xfer_cnt, xfer_nx;

    logic [1:0]  grant_nx;
    logic [15:0] cmd_nx;
    logic        wrt_nx;
    logic        done0_nx, done1_nx;
    logic [15:0] rd0_nx, rd1_nx;
    logic        err_nx;
    logic        take1;
    logic        finish;

    assign busy = (state != IDLE);

    // State, counters and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            starve_cnt  <= '0;
            xfer_cnt    <= '0;
            grant       <= GRANT_NONE;
            spi_cmd     <= '0;
            spi_wrt     <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            rd0         <= '0;
            rd1         <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            gap_cnt     <= gap_nx;
            starve_cnt  <= starve_nx;
            xfer_cnt    <= xfer_nx;
            grant       <= grant_nx;
            spi_cmd     <= cmd_nx;
            spi_wrt     <= wrt_nx;
            done0       <= done0_nx;
            done1       <= done1_nx;
            rd0         <= rd0_nx;
            rd1         <= rd1_nx;
            timeout_err <= err_nx;
        end
    end

    // Next-state and next-output logic for arbitration, transfer and gap.
    always_comb begin
        state_nx  = state;
        gap_nx    = gap_cnt;
        starve_nx = starve_cnt;
        xfer_nx   = xfer_cnt;
        grant_nx  = grant;
        cmd_nx    = spi_cmd;
        wrt_nx    = 1'b0;
        done0_nx  = 1'b0;
        done1_nx  = 1'b0;
        rd0_nx    = rd0;
        rd1_nx    = rd1;
        // A timeout in the same cycle overrides the clear below.
        err_nx    = timeout_err & ~clr_err;
        take1     = 1'b0;
        finish    = 1'b0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    take1 = pick_req1(req0, req1, starve_cnt == STARVE_MAX);
                    if (take1) begin
                        grant_nx  = GRANT1;
                        cmd_nx    = cmd1;
                        starve_nx = '0;
                    end else begin
                        grant_nx = GRANT0;
                        cmd_nx   = cmd0;
                        if (!req1) begin
                            starve_nx = '0;
                        end else if (starve_cnt != STARVE_MAX) begin
                            starve_nx = starve_cnt + SW'(1);
                        end
                    end
                    wrt_nx   = 1'b1;
                    xfer_nx  = '0;
                    state_nx = XFER;
                end
            end

            XFER: begin
                if (spi_done) begin
                    finish = 1'b1;
                    if (grant[0]) rd0_nx = spi_rd;
                    if (grant[1]) rd1_nx = spi_rd;
                end else if (xfer_cnt == XFER_LAST) begin
                    finish = 1'b1;
                    err_nx = 1'b1;
                end else begin
                    xfer_nx = xfer_cnt + TW'(1);
                end
                if (finish) begin
                    done0_nx = grant[0];
                    done1_nx = grant[1];
                    gap_nx   = '0;
                    state_nx = GAP;
                end
            end

            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_nx   = '0;
                    grant_nx = GRANT_NONE;
                    state_nx = IDLE;
                end else begin
                    gap_nx = gap_cnt + GW'(1);
                end
            end

            default: begin
                grant_nx = GRANT_NONE;
                state_nx = IDLE;
            end
        endcase
    end

endmodule
